seg_decode_capture: RTL and testbench
=====================================

SEG_DECODE_CAPTURE -- requirements
Module: seg_decode_capture

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, number of consecutive identical samples required before a digit is decoded (legal range 1..255).
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 seg  input  7  active-low segment bus, bit6=a ... bit0=g.
REQ-005 an  input  4  active-low digit select; exactly one low bit means that digit is driven.
REQ-006 out_ready  input  1  consumer accepts the current result.
REQ-007 out_valid  output  1  decoded result available.
REQ-008 out_digit  output  2  index of the low bit of an for the result.
REQ-009 out_value  output  4  decoded value: 0-9, 4'hF dash, 4'hE error.
REQ-010 out_err  output  1  result pattern was not in the decode table.
REQ-011 digit_vals  output  16  last good value per digit, digit n in bits [4n+3:4n].
REQ-012 err_count  output  8  saturating count of error results.

Function
REQ-013 Decode table, seg to value: 0000001=0, 1001111=1, 0010010=2, 0000110=3, 1001100=4, 0100100=5, 0100000=6, 0001101=7, 0000000=8, 0000100=9, 1111110=4'hF (dash); any other pattern is an error.
REQ-014 The FSM states SHALL be IDLE, SETTLE, EMIT and WAIT_CHANGE.
REQ-015 IDLE: if an is one-hot-low, capture {an,seg}, set stable counter to 1 and go to SETTLE; otherwise stay.
REQ-016 SETTLE: if the sample equals the capture, increment the counter; if it differs and an is one-hot-low, recapture and set the counter to 1; if an is not one-hot-low, go to IDLE.
REQ-017 SETTLE: when the counter reaches STABLE_CYCLES, decode the capture, register the outputs and go to EMIT, so out_valid rises on the edge after the STABLE_CYCLES-th identical sample.
REQ-018 With STABLE_CYCLES=1, IDLE SHALL go directly to EMIT on the first valid sample.
REQ-019 EMIT: out_valid=1 and out_digit, out_value and out_err SHALL be held constant until a cycle with out_ready=1; then out_valid=0 on the next edge and the FSM goes to WAIT_CHANGE.
REQ-020 Input changes during EMIT SHALL be ignored; the capture is retained.
REQ-021 WAIT_CHANGE: stay while the sample equals the capture, so one stable display produces exactly one result; on any difference, take the IDLE action for that sample in the same cycle.
REQ-022 A good result (0-9 or dash) SHALL write out_value into the digit_vals nibble on the same edge that out_valid rises.
REQ-023 An error result SHALL set out_err=1 and out_value=4'hE, leave digit_vals unchanged, and increment err_count, which saturates at 255.
REQ-024 An an value with more than one bit low, or with all bits high, SHALL never produce a result.

Reset
REQ-025 While reset=1 at a clock edge: state=IDLE, out_valid=0, out_digit=0, out_value=0, out_err=0, digit_vals=16'hFFFF (all dash), err_count=0, stable counter=0 and capture=all ones.
REQ-026 Reset asserted in any state, including mid-EMIT without a handshake, SHALL abort the operation with no result delivered; sampling resumes on the first edge after reset deasserts.

Structure
REQ-027 Package seg_pkg SHALL hold the ten digit pattern constants, the dash pattern, the DASH=4'hF and ERR=4'hE codes, and the FSM state enum.
REQ-028 Table lookup SHALL live in a combinational sub-module seg_pattern_decode (input seg; outputs value, is_err), instantiated once.
REQ-029 The stable counter SHALL be 8 bits wide and SHALL not wrap.

Verification
REQ-030 Hold an=1110 and seg=0010010 with out_ready=1 and STABLE_CYCLES=4 -> out_valid high for 1 cycle on the 5th edge, digit=0, value=2, digit_vals[3:0]=2, and no second result while the inputs stay unchanged.
REQ-031 With an=1011, toggle seg between 1001111 and 0000110 every 2 cycles for 20 cycles, then hold 0000110 -> no result during toggling; after the hold, a single result with digit=2, value=3.
REQ-032 Hold an=0111 and seg=1010101 -> out_err=1, value=4'hE, digit_vals unchanged, err_count=1; repeat 300 distinct events -> err_count=255.
REQ-033 Produce a result with out_ready=0 for 10 cycles while seg changes -> outputs constant for the whole stall; the handshake on cycle 11 is followed by a new result for the changed pattern.
REQ-034 Hold an=1100 or an=1111 with any seg -> out_valid never rises.
REQ-035 Assert reset during EMIT -> next cycle out_valid=0, digit_vals=FFFF, err_count=0; the same stable input then yields a fresh result STABLE_CYCLES+1 edges after reset deasserts.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment capture block: active-low segment
// patterns (bit6=a ... bit0=g), result codes and the capture FSM states.
package seg_pkg;

  localparam logic [6:0] SEG_0    = 7'b0000001;
  localparam logic [6:0] SEG_1    = 7'b1001111;
  localparam logic [6:0] SEG_2    = 7'b0010010;
  localparam logic [6:0] SEG_3    = 7'b0000110;
  localparam logic [6:0] SEG_4    = 7'b1001100;
  localparam logic [6:0] SEG_5    = 7'b0100100;
  localparam logic [6:0] SEG_6    = 7'b0100000;
  localparam logic [6:0] SEG_7    = 7'b0001101;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0000100;
  localparam logic [6:0] SEG_DASH = 7'b1111110;

  localparam logic [3:0] DASH = 4'hF;
  localparam logic [3:0] ERR  = 4'hE;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    EMIT,
    WAIT_CHANGE
  } state_t;

  // Position of the single low bit in an active-low digit select.
  function automatic logic [1:0] an_index(input logic [3:0] an);
    case (an)
      4'b1101: return 2'd1;
      4'b1011: return 2'd2;
      4'b0111: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational seven-segment pattern lookup: digit 0-9, dash, or error.
module seg_pattern_decode
  import seg_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] value,
  output logic       is_err
);

  // Table lookup; anything outside the table is flagged as an error.
  always_comb begin
    value  = ERR;
    is_err = 1'b0;
    case (seg)
      SEG_0:    value = 4'd0;
      SEG_1:    value = 4'd1;
      SEG_2:    value = 4'd2;
      SEG_3:    value = 4'd3;
      SEG_4:    value = 4'd4;
      SEG_5:    value = 4'd5;
      SEG_6:    value = 4'd6;
      SEG_7:    value = 4'd7;
      SEG_8:    value = 4'd8;
      SEG_9:    value = 4'd9;
      SEG_DASH: value = DASH;
      default: begin
        value  = ERR;
        is_err = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/seg_decode_capture.sv
// Samples a multiplexed seven-segment display, waits for a stable pattern,
// decodes it once and hands the result over with a valid/ready handshake.
module seg_decode_capture
  import seg_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  seg,
  input  logic [3:0]  an,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [1:0]  out_digit,
  output logic [3:0]  out_value,
  output logic        out_err,
  output logic [15:0] digit_vals,
  output logic [7:0]  err_count
);

  localparam logic [7:0] STABLE_N = 8'(STABLE_CYCLES);
  // A single required sample means the first valid sample is emitted directly.
  localparam bit DIRECT = (STABLE_CYCLES == 32'd1);

  state_t      r_state, w_state_next;
  logic [10:0] r_cap, w_cap_next;
  logic [7:0]  r_cnt, w_cnt_next;
  logic        r_valid, w_valid_next;
  logic [1:0]  r_digit, w_digit_next;
  logic [3:0]  r_value, w_value_next;
  logic        r_err, w_err_next;
  logic [15:0] r_vals, w_vals_next;
  logic [7:0]  r_err_count, w_err_count_next;

  logic [10:0] w_sample;
  logic        w_an_ok;
  logic        w_same;
  logic        w_emit;
  logic [10:0] w_dec_src;
  logic [1:0]  w_dec_idx;
  logic [3:0]  w_dec_value;
  logic        w_dec_err;

  assign w_sample = {an, seg};
  assign w_an_ok  = (an == 4'b1110) || (an == 4'b1101) || (an == 4'b1011) || (an == 4'b0111);
  assign w_same   = (w_sample == r_cap);

  // SETTLE decodes the held capture; a direct emit decodes the live sample.
  assign w_dec_src = (r_state == SETTLE) ? r_cap : w_sample;
  assign w_dec_idx = an_index(w_dec_src[10:7]);

  seg_pattern_decode u_decode (
    .seg    (w_dec_src[6:0]),
    .value  (w_dec_value),
    .is_err (w_dec_err)
  );

  // Next-state, capture/counter update and result registration.
  always_comb begin
    w_state_next     = r_state;
    w_cap_next       = r_cap;
    w_cnt_next       = r_cnt;
    w_valid_next     = r_valid;
    w_digit_next     = r_digit;
    w_value_next     = r_value;
    w_err_next       = r_err;
    w_vals_next      = r_vals;
    w_err_count_next = r_err_count;
    w_emit           = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_an_ok) begin
          w_cap_next = w_sample;
          w_cnt_next = 8'd1;
          if (DIRECT) w_emit = 1'b1;
          else        w_state_next = SETTLE;
        end
      end
      SETTLE: begin
        if (r_cnt >= STABLE_N) begin
          w_emit = 1'b1;
        end else if (w_same) begin
          if (r_cnt != 8'hFF) w_cnt_next = r_cnt + 8'd1;
        end else if (w_an_ok) begin
          w_cap_next = w_sample;
          w_cnt_next = 8'd1;
        end else begin
          w_cnt_next   = 8'd0;
          w_state_next = IDLE;
        end
      end
      EMIT: begin
        // Inputs are ignored here; only the handshake moves us on.
        if (out_ready) begin
          w_valid_next = 1'b0;
          w_state_next = WAIT_CHANGE;
        end
      end
      WAIT_CHANGE: begin
        // A change is treated exactly like a fresh sample seen in IDLE.
        if (!w_same) begin
          if (w_an_ok) begin
            w_cap_next = w_sample;
            w_cnt_next = 8'd1;
            if (DIRECT) w_emit = 1'b1;
            else        w_state_next = SETTLE;
          end else begin
            w_cnt_next   = 8'd0;
            w_state_next = IDLE;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase

    if (w_emit) begin
      w_state_next = EMIT;
      w_valid_next = 1'b1;
      w_digit_next = w_dec_idx;
      w_err_next   = w_dec_err;
      if (w_dec_err) begin
        w_value_next = ERR;
        if (r_err_count != 8'hFF) w_err_count_next = r_err_count + 8'd1;
      end else begin
        w_value_next = w_dec_value;
        w_vals_next[{w_dec_idx, 2'b00} +: 4] = w_dec_value;
      end
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cap       <= '1;
      r_cnt       <= 8'd0;
      r_valid     <= 1'b0;
      r_digit     <= 2'd0;
      r_value     <= 4'd0;
      r_err       <= 1'b0;
      r_vals      <= 16'hFFFF;
      r_err_count <= 8'd0;
    end else begin
      r_state     <= w_state_next;
      r_cap       <= w_cap_next;
      r_cnt       <= w_cnt_next;
      r_valid     <= w_valid_next;
      r_digit     <= w_digit_next;
      r_value     <= w_value_next;
      r_err       <= w_err_next;
      r_vals      <= w_vals_next;
      r_err_count <= w_err_count_next;
    end
  end

  assign out_valid  = r_valid;
  assign out_digit  = r_digit;
  assign out_value  = r_value;
  assign out_err    = r_err;
  assign digit_vals = r_vals;
  assign err_count  = r_err_count;

endmodule

// File: tb/tb_seg_decode_capture.sv
// Directed bench for seg_decode_capture (default STABLE_CYCLES=4) plus a
// second instance with STABLE_CYCLES=1 for the direct-emit path.
module tb_seg_decode_capture;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        out_ready;
  logic        out_valid;
  logic [1:0]  out_digit;
  logic [3:0]  out_value;
  logic        out_err;
  logic [15:0] digit_vals;
  logic [7:0]  err_count;

  logic        o1_valid;
  logic [1:0]  o1_digit;
  logic [3:0]  o1_value;
  logic        o1_err;
  logic [15:0] o1_vals;
  logic [7:0]  o1_err_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seg_decode_capture #(.STABLE_CYCLES(4)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .seg        (seg),
    .an         (an),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_digit  (out_digit),
    .out_value  (out_value),
    .out_err    (out_err),
    .digit_vals (digit_vals),
    .err_count  (err_count)
  );

  seg_decode_capture #(.STABLE_CYCLES(1)) u_dut1 (
    .clk        (clk),
    .reset      (reset),
    .seg        (seg),
    .an         (an),
    .out_ready  (out_ready),
    .out_valid  (o1_valid),
    .out_digit  (o1_digit),
    .out_value  (o1_value),
    .out_err    (o1_err),
    .digit_vals (o1_vals),
    .err_count  (o1_err_count)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; an = 4'b1111; seg = 7'h7F; out_ready = 1'b1;
    step(2);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    checks++; if (out_digit !== 2'd0) begin errors++; $display("FAIL reset_digit: got %0d expected 0", out_digit); end
    checks++; if (out_value !== 4'h0) begin errors++; $display("FAIL reset_value: got %h expected 0", out_value); end
    checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", out_err); end
    checks++; if (digit_vals !== 16'hFFFF) begin errors++; $display("FAIL reset_vals: got %h expected ffff", digit_vals); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL reset_errcnt: got %0d expected 0", err_count); end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int early = 0;
    int extra = 0;
    an = 4'b1110; seg = 7'b0010010; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1);
      if (out_valid) early++;
    end
    checks++; if (early !== 0) begin errors++; $display("FAIL basic_early: got %0d results expected 0", early); end
    step(1);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid5: got %b expected 1", out_valid); end
    checks++; if (out_digit !== 2'd0) begin errors++; $display("FAIL basic_digit: got %0d expected 0", out_digit); end
    checks++; if (out_value !== 4'h2) begin errors++; $display("FAIL basic_value: got %h expected 2", out_value); end
    checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL basic_err: got %b expected 0", out_err); end
    checks++; if (digit_vals !== 16'hFFF2) begin errors++; $display("FAIL basic_vals: got %h expected fff2", digit_vals); end
    step(1);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_one_cycle: got %b expected 0", out_valid); end
    for (int i = 0; i < 12; i++) begin
      step(1);
      if (out_valid) extra++;
    end
    checks++; if (extra !== 0) begin errors++; $display("FAIL basic_no_repeat: got %0d results expected 0", extra); end
  endtask

  task automatic test_toggle();
    int during = 0;
    int after = 0;
    logic [1:0] got_digit = 2'd0;
    logic [3:0] got_value = 4'h0;
    an = 4'b1011; out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      seg = (i % 2 == 0) ? 7'b1001111 : 7'b0000110;
      for (int j = 0; j < 2; j++) begin
        step(1);
        if (out_valid) during++;
      end
    end
    checks++; if (during !== 0) begin errors++; $display("FAIL toggle_quiet: got %0d results expected 0", during); end
    seg = 7'b0000110;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (out_valid) begin
        after++;
        got_digit = out_digit;
        got_value = out_value;
      end
    end
    checks++; if (after !== 1) begin errors++; $display("FAIL toggle_count: got %0d results expected 1", after); end
    checks++; if (got_digit !== 2'd2) begin errors++; $display("FAIL toggle_digit: got %0d expected 2", got_digit); end
    checks++; if (got_value !== 4'h3) begin errors++; $display("FAIL toggle_value: got %h expected 3", got_value); end
    checks++; if (digit_vals !== 16'hF3F2) begin errors++; $display("FAIL toggle_vals: got %h expected f3f2", digit_vals); end
  endtask

  task automatic test_error();
    int results = 0;
    an = 4'b0111; seg = 7'b1010101; out_ready = 1'b1;
    step(5);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL err_valid: got %b expected 1", out_valid); end
    checks++; if (out_err !== 1'b1) begin errors++; $display("FAIL err_flag: got %b expected 1", out_err); end
    checks++; if (out_value !== 4'hE) begin errors++; $display("FAIL err_value: got %h expected e", out_value); end
    checks++; if (out_digit !== 2'd3) begin errors++; $display("FAIL err_digit: got %0d expected 3", out_digit); end
    checks++; if (digit_vals !== 16'hF3F2) begin errors++; $display("FAIL err_vals: got %h expected f3f2", digit_vals); end
    checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL err_count1: got %0d expected 1", err_count); end
    for (int i = 0; i < 300; i++) begin
      seg = (i % 2 == 0) ? 7'b1111111 : 7'b1010101;
      for (int j = 0; j < 7; j++) begin
        step(1);
        if (out_valid) results++;
      end
    end
    checks++; if (results !== 300) begin errors++; $display("FAIL err_events: got %0d results expected 300", results); end
    checks++; if (err_count !== 8'd255) begin errors++; $display("FAIL err_saturate: got %0d expected 255", err_count); end
    checks++; if (digit_vals !== 16'hF3F2) begin errors++; $display("FAIL err_vals_kept: got %h expected f3f2", digit_vals); end
  endtask

  task automatic test_stall();
    bit found = 1'b0;
    an = 4'b1101; seg = 7'b0100100; out_ready = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step(1);
      if (out_valid) found = 1'b1;
    end
    checks++; if (found !== 1'b1) begin errors++; $display("FAIL stall_first: got no result expected one"); end
    checks++; if (out_value !== 4'h5) begin errors++; $display("FAIL stall_value: got %h expected 5", out_value); end
    checks++; if (digit_vals !== 16'hF352) begin errors++; $display("FAIL stall_vals: got %h expected f352", digit_vals); end
    seg = 7'b0001101;
    for (int i = 0; i < 10; i++) begin
      step(1);
      checks++;
      if ({out_valid, out_digit, out_value, out_err} !== {1'b1, 2'd1, 4'h5, 1'b0}) begin
        errors++;
        $display("FAIL stall_hold: got v=%b d=%0d val=%h e=%b expected v=1 d=1 val=5 e=0",
                 out_valid, out_digit, out_value, out_err);
      end
    end
    out_ready = 1'b1;
    step(1);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_release: got %b expected 0", out_valid); end
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step(1);
      if (out_valid) found = 1'b1;
    end
    checks++; if (found !== 1'b1) begin errors++; $display("FAIL stall_second: got no result expected one"); end
    checks++; if (out_value !== 4'h7) begin errors++; $display("FAIL stall_value2: got %h expected 7", out_value); end
    checks++; if (digit_vals !== 16'hF372) begin errors++; $display("FAIL stall_vals2: got %h expected f372", digit_vals); end
  endtask

  task automatic test_bad_an();
    int results = 0;
    out_ready = 1'b1; seg = 7'b0000000;
    an = 4'b1100;
    for (int i = 0; i < 12; i++) begin
      step(1);
      if (out_valid) results++;
    end
    checks++; if (results !== 0) begin errors++; $display("FAIL bad_an_two_low: got %0d results expected 0", results); end
    an = 4'b1111;
    for (int i = 0; i < 12; i++) begin
      step(1);
      if (out_valid) results++;
    end
    checks++; if (results !== 0) begin errors++; $display("FAIL bad_an_none_low: got %0d results expected 0", results); end
  endtask

  task automatic test_reset_emit();
    bit found = 1'b0;
    int early = 0;
    an = 4'b1110; seg = 7'b0000100; out_ready = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step(1);
      if (out_valid) found = 1'b1;
    end
    checks++; if (found !== 1'b1) begin errors++; $display("FAIL rst_emit_first: got no result expected one"); end
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_emit_valid: got %b expected 0", out_valid); end
    checks++; if (digit_vals !== 16'hFFFF) begin errors++; $display("FAIL rst_emit_vals: got %h expected ffff", digit_vals); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL rst_emit_errcnt: got %0d expected 0", err_count); end
    for (int i = 0; i < 4; i++) begin
      step(1);
      if (out_valid) early++;
    end
    checks++; if (early !== 0) begin errors++; $display("FAIL rst_emit_early: got %0d results expected 0", early); end
    step(1);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_emit_fresh: got %b expected 1", out_valid); end
    checks++; if (out_value !== 4'h9) begin errors++; $display("FAIL rst_emit_value: got %h expected 9", out_value); end
    checks++; if (digit_vals !== 16'hFFF9) begin errors++; $display("FAIL rst_emit_vals2: got %h expected fff9", digit_vals); end
    out_ready = 1'b1;
    step(1);
  endtask

  task automatic test_stable_one();
    int extra = 0;
    reset = 1'b1; an = 4'b1111; seg = 7'h7F; out_ready = 1'b1;
    step(1);
    reset = 1'b0;
    an = 4'b1101; seg = 7'b0000001;
    step(1);
    checks++; if (o1_valid !== 1'b1) begin errors++; $display("FAIL one_valid: got %b expected 1", o1_valid); end
    checks++; if (o1_value !== 4'h0) begin errors++; $display("FAIL one_value: got %h expected 0", o1_value); end
    checks++; if (o1_digit !== 2'd1) begin errors++; $display("FAIL one_digit: got %0d expected 1", o1_digit); end
    checks++; if (o1_vals !== 16'hFF0F) begin errors++; $display("FAIL one_vals: got %h expected ff0f", o1_vals); end
    step(1);
    checks++; if (o1_valid !== 1'b0) begin errors++; $display("FAIL one_drop: got %b expected 0", o1_valid); end
    for (int i = 0; i < 6; i++) begin
      step(1);
      if (o1_valid) extra++;
    end
    checks++; if (extra !== 0) begin errors++; $display("FAIL one_no_repeat: got %0d results expected 0", extra); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_toggle();
    test_error();
    test_stall();
    test_bad_an();
    test_reset_emit();
    test_stable_one();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
